// File: rtl/frame_mem_ctrl_pkg.sv
// Shared constants and state/tag types for the 160x120 frame memory controller.
package frame_mem_ctrl_pkg;

  localparam int unsigned NUM_PIXELS   = 19200;
  localparam int unsigned ADDR_W       = 15;
  localparam int unsigned DATA_W       = 16;
  localparam int unsigned STARVE_LIMIT = 8;
  localparam int unsigned STARVE_W     = $clog2(STARVE_LIMIT + 1);

  localparam logic [ADDR_W-1:0]   LAST_ADDR  = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [ADDR_W-1:0]   PIX_LIMIT  = ADDR_W'(NUM_PIXELS);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {WAIT_SOF, CAPTURE, FROZEN} wr_state_e;
  typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_DET} rd_tag_e;

endpackage

// File: rtl/frame_rd_arbiter.sv
// Single read-port arbiter: display-first with detector starvation guard,
// one-cycle tagged return path.
module frame_rd_arbiter
  import frame_mem_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              det_req,
  input  logic [ADDR_W-1:0] det_addr,
  output logic              det_gnt,
  output logic              det_valid,
  output logic [DATA_W-1:0] det_data,
  output logic              enb,
  output logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] dob
);

  logic [STARVE_W-1:0] starve_q, starve_d;
  rd_tag_e             tag_q, tag_d;
  logic                oor_q, oor_d;
  logic [ADDR_W-1:0]   sel_addr;
  logic                sel_oor;

  always_comb begin
    disp_gnt = 1'b0;
    det_gnt  = 1'b0;
    if (!rst) begin
      if (det_req && starve_q == STARVE_MAX) begin
        det_gnt = 1'b1;
      end else if (disp_req) begin
        disp_gnt = 1'b1;
      end else if (det_req) begin
        det_gnt = 1'b1;
      end
    end

    // Out-of-range requests are still granted; only the memory access is suppressed.
    sel_addr = det_gnt ? det_addr : disp_addr;
    sel_oor  = (sel_addr >= PIX_LIMIT);
    enb      = (disp_gnt || det_gnt) && !sel_oor;
    addrb    = enb ? sel_addr : '0;

    starve_d = (det_req && !det_gnt) ? starve_q + STARVE_W'(1) : '0;

    tag_d = TAG_NONE;
    if (det_gnt) begin
      tag_d = TAG_DET;
    end else if (disp_gnt) begin
      tag_d = TAG_DISP;
    end
    oor_d = (disp_gnt || det_gnt) && sel_oor;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
      tag_q    <= TAG_NONE;
      oor_q    <= 1'b0;
    end else begin
      starve_q <= starve_d;
      tag_q    <= tag_d;
      oor_q    <= oor_d;
    end
  end

  always_comb begin
    disp_valid = 1'b0;
    det_valid  = 1'b0;
    disp_data  = '0;
    det_data   = '0;
    if (!rst) begin
      case (tag_q)
        TAG_DISP: begin
          disp_valid = 1'b1;
          if (!oor_q) disp_data = dob;
        end
        TAG_DET: begin
          det_valid = 1'b1;
          if (!oor_q) det_data = dob;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/frame_mem_ctrl.sv
// Frame memory controller: camera write sequencing with SOF alignment,
// overrun restart and freeze, plus the shared read-port arbiter.
module frame_mem_ctrl
  import frame_mem_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cam_valid,
  input  logic              cam_sof,
  input  logic [DATA_W-1:0] cam_data,
  input  logic              freeze_req,
  output logic              frozen,
  output logic              frame_done,
  output logic              frame_err,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              det_req,
  input  logic [ADDR_W-1:0] det_addr,
  output logic              det_gnt,
  output logic              det_valid,
  output logic [DATA_W-1:0] det_data,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dia,
  output logic              enb,
  output logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] dob
);

  wr_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              done_c;
  logic              err_c;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_addr = '0;
    done_c  = 1'b0;
    err_c   = 1'b0;
    case (state_q)
      WAIT_SOF: begin
        if (cam_sof) begin
          state_d = CAPTURE;
          wr_en   = cam_valid;
          cnt_d   = cam_valid ? ADDR_W'(1) : '0;
        end
      end
      CAPTURE: begin
        // An SOF always restarts at address 0; it is only an error mid-frame.
        if (cam_sof) begin
          err_c = (cnt_q != '0);
          wr_en = cam_valid;
          cnt_d = cam_valid ? ADDR_W'(1) : '0;
        end else if (cam_valid) begin
          wr_en   = 1'b1;
          wr_addr = cnt_q;
          if (cnt_q == LAST_ADDR) begin
            done_c  = 1'b1;
            cnt_d   = '0;
            state_d = freeze_req ? FROZEN : WAIT_SOF;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      FROZEN: begin
        if (!freeze_req) state_d = WAIT_SOF;
      end
      default: state_d = WAIT_SOF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_SOF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ena        = wr_en && !rst;
  assign wea        = ena;
  assign addra      = ena ? wr_addr : '0;
  assign dia        = ena ? cam_data : '0;
  assign frame_done = done_c && !rst;
  assign frame_err  = err_c && !rst;
  assign frozen     = (state_q == FROZEN) && !rst;

  frame_rd_arbiter u_rd_arb (
    .clk        (clk),
    .rst        (rst),
    .disp_req   (disp_req),
    .disp_addr  (disp_addr),
    .disp_gnt   (disp_gnt),
    .disp_valid (disp_valid),
    .disp_data  (disp_data),
    .det_req    (det_req),
    .det_addr   (det_addr),
    .det_gnt    (det_gnt),
    .det_valid  (det_valid),
    .det_data   (det_data),
    .enb        (enb),
    .addrb      (addrb),
    .dob        (dob)
  );

endmodule

// File: tb/tb_frame_mem_ctrl.sv
// Self-checking bench for frame_mem_ctrl with a behavioural read-before-write
// memory and write/read scoreboards.
module tb_frame_mem_ctrl;
  import frame_mem_ctrl_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              cam_valid, cam_sof, freeze_req;
  logic [DATA_W-1:0] cam_data;
  logic              frozen, frame_done, frame_err;
  logic              disp_req, disp_gnt, disp_valid;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              det_req, det_gnt, det_valid;
  logic [ADDR_W-1:0] det_addr;
  logic [DATA_W-1:0] det_data;
  logic              ena, wea, enb;
  logic [ADDR_W-1:0] addra, addrb;
  logic [DATA_W-1:0] dia;
  logic [DATA_W-1:0] dob = '0;

  logic [DATA_W-1:0] mem [0:32767];

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;
  typedef struct {
    logic              det;
    logic [DATA_W-1:0] data;
  } rd_t;

  wr_t wq[$];
  rd_t rq[$];
  wr_t wr_exp;
  rd_t rd_exp;

  int checks = 0;
  int errors = 0;

  logic [87:0] all_out;
  assign all_out = {frozen, frame_done, frame_err, disp_gnt, disp_valid, disp_data,
                    det_gnt, det_valid, det_data, ena, wea, addra, dia, enb, addrb};

  frame_mem_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cam_valid  (cam_valid),
    .cam_sof    (cam_sof),
    .cam_data   (cam_data),
    .freeze_req (freeze_req),
    .frozen     (frozen),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .disp_req   (disp_req),
    .disp_addr  (disp_addr),
    .disp_gnt   (disp_gnt),
    .disp_valid (disp_valid),
    .disp_data  (disp_data),
    .det_req    (det_req),
    .det_addr   (det_addr),
    .det_gnt    (det_gnt),
    .det_valid  (det_valid),
    .det_data   (det_data),
    .ena        (ena),
    .wea        (wea),
    .addra      (addra),
    .dia        (dia),
    .enb        (enb),
    .addrb      (addrb),
    .dob        (dob)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ena && wea) mem[addra] <= dia;
    if (enb) dob <= mem[addrb];
  end

  function automatic logic [DATA_W-1:0] pix(input int unsigned f, input int unsigned a);
    return DATA_W'(a * 5 + f * 11037);
  endfunction

  always @(negedge clk) begin
    if (ena === 1'b1 || wea === 1'b1) begin
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected addra=%0d dia=%h, expected no write", addra, dia);
      end else begin
        wr_exp = wq.pop_front();
        if (ena !== 1'b1 || wea !== 1'b1 || addra !== wr_exp.addr || dia !== wr_exp.data) begin
          errors++;
          $display("FAIL wr_data ena=%b wea=%b addra=%0d dia=%h, expected 1 1 %0d %h",
                   ena, wea, addra, dia, wr_exp.addr, wr_exp.data);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (disp_valid === 1'b1 || det_valid === 1'b1) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected disp_valid=%b det_valid=%b, expected none", disp_valid, det_valid);
      end else begin
        rd_exp = rq.pop_front();
        if ({disp_valid, det_valid, disp_data, det_data} !==
            (rd_exp.det ? {2'b01, 16'h0000, rd_exp.data} : {2'b10, rd_exp.data, 16'h0000})) begin
          errors++;
          $display("FAIL rd_return dv=%b tv=%b dd=%h td=%h, expected det=%b data=%h",
                   disp_valid, det_valid, disp_data, det_data, rd_exp.det, rd_exp.data);
        end
      end
    end
  end

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic to_sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    cam_valid  = 1'b0;
    cam_sof    = 1'b0;
    cam_data   = '0;
    disp_req   = 1'b0;
    det_req    = 1'b0;
    disp_addr  = '0;
    det_addr   = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    freeze_req = 1'b0;
    idle_inputs();
    repeat (3) to_drive();
    to_sample();
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%h, expected 0", all_out);
    end
    to_drive();
    rst = 1'b0;
    to_sample();
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL post_reset_outputs got=%h, expected 0", all_out);
    end
  endtask

  task automatic test_full_frame();
    for (int unsigned a = 0; a < NUM_PIXELS; a++) begin
      to_drive();
      cam_sof   = (a == 0);
      cam_valid = 1'b1;
      cam_data  = pix(1, a);
      wq.push_back('{addr: ADDR_W'(a), data: pix(1, a)});
      to_sample();
      checks++;
      if ({frame_done, frame_err, frozen} !== {(a == NUM_PIXELS - 1), 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL full_frame_flags a=%0d done/err/frozen=%b%b%b, expected %b00",
                 a, frame_done, frame_err, frozen, (a == NUM_PIXELS - 1));
      end
    end
    to_drive();
    cam_sof   = 1'b0;
    cam_valid = 1'b1;
    to_sample();
    checks++;
    if ({ena, frame_done} !== 2'b00) begin
      errors++;
      $display("FAIL full_frame_back_to_wait ena=%b done=%b, expected 00", ena, frame_done);
    end
    to_drive();
    idle_inputs();
  endtask

  task automatic test_arbitration();
    int unsigned n_disp = 0;
    logic        exp_det;
    logic [ADDR_W-1:0] exp_addr;
    disp_req = 1'b1;
    det_req  = 1'b1;
    for (int unsigned k = 0; k < 27; k++) begin
      disp_addr = ADDR_W'(100 + n_disp);
      det_addr  = ADDR_W'(5000 + k / 9);
      to_sample();
      exp_det  = (k % 9 == 8);
      exp_addr = exp_det ? det_addr : disp_addr;
      checks++;
      if ({disp_gnt, det_gnt, enb, addrb} !== {!exp_det, exp_det, 1'b1, exp_addr}) begin
        errors++;
        $display("FAIL arb_grant k=%0d dg=%b tg=%b enb=%b addrb=%0d, expected %b %b 1 %0d",
                 k, disp_gnt, det_gnt, enb, addrb, !exp_det, exp_det, exp_addr);
      end
      rq.push_back('{det: exp_det, data: pix(1, exp_addr)});
      if (!exp_det) n_disp++;
      to_drive();
    end
    disp_req = 1'b0;
    det_req  = 1'b0;
    to_sample();
    #1;
    checks++;
    if (rq.size() != 0 || disp_gnt !== 1'b0 || det_gnt !== 1'b0) begin
      errors++;
      $display("FAIL arb_drain pending=%0d dg=%b tg=%b, expected 0 0 0", rq.size(), disp_gnt, det_gnt);
    end
  endtask

  task automatic test_out_of_range();
    to_drive();
    det_req  = 1'b1;
    det_addr = ADDR_W'(NUM_PIXELS);
    to_sample();
    checks++;
    if ({det_gnt, disp_gnt, enb} !== 3'b100) begin
      errors++;
      $display("FAIL oor_det_grant tg/dg/enb=%b%b%b, expected 100", det_gnt, disp_gnt, enb);
    end
    rq.push_back('{det: 1'b1, data: '0});
    to_drive();
    det_addr = LAST_ADDR;
    to_sample();
    checks++;
    if ({det_gnt, enb, addrb} !== {2'b11, LAST_ADDR}) begin
      errors++;
      $display("FAIL last_addr_grant tg=%b enb=%b addrb=%0d, expected 1 1 %0d", det_gnt, enb, addrb, LAST_ADDR);
    end
    rq.push_back('{det: 1'b1, data: pix(1, NUM_PIXELS - 1)});
    to_drive();
    det_req   = 1'b0;
    disp_req  = 1'b1;
    disp_addr = '1;
    to_sample();
    checks++;
    if ({disp_gnt, det_gnt, enb} !== 3'b100) begin
      errors++;
      $display("FAIL oor_disp_grant dg/tg/enb=%b%b%b, expected 100", disp_gnt, det_gnt, enb);
    end
    rq.push_back('{det: 1'b0, data: '0});
    to_drive();
    idle_inputs();
    to_sample();
    #1;
    checks++;
    if (rq.size() != 0) begin
      errors++;
      $display("FAIL oor_drain pending=%0d, expected 0", rq.size());
    end
  endtask

  task automatic test_sof_align();
    for (int unsigned i = 0; i < 3; i++) begin
      to_drive();
      cam_valid = 1'b1;
      cam_sof   = 1'b0;
      cam_data  = 16'hBEEF;
      to_sample();
      checks++;
      if ({ena, frame_err, frame_done} !== 3'b000) begin
        errors++;
        $display("FAIL wait_sof_ignore ena/err/done=%b%b%b, expected 000", ena, frame_err, frame_done);
      end
    end
    to_drive();
    cam_sof   = 1'b1;
    cam_valid = 1'b0;
    to_sample();
    checks++;
    if ({ena, frame_err} !== 2'b00) begin
      errors++;
      $display("FAIL sof_no_valid ena/err=%b%b, expected 00", ena, frame_err);
    end
    for (int unsigned a = 0; a < 500; a++) begin
      to_drive();
      cam_sof   = 1'b0;
      cam_valid = 1'b1;
      cam_data  = pix(2, a);
      wq.push_back('{addr: ADDR_W'(a), data: pix(2, a)});
      to_sample();
    end
    to_drive();
    cam_sof  = 1'b1;
    cam_data = pix(3, 0);
    wq.push_back('{addr: '0, data: pix(3, 0)});
    to_sample();
    checks++;
    if ({frame_err, ena, addra} !== {2'b11, ADDR_W'(0)}) begin
      errors++;
      $display("FAIL sof_mid_frame err=%b ena=%b addra=%0d, expected 1 1 0", frame_err, ena, addra);
    end
    to_drive();
    cam_sof  = 1'b0;
    cam_data = pix(3, 1);
    wq.push_back('{addr: ADDR_W'(1), data: pix(3, 1)});
    to_sample();
    checks++;
    if ({frame_err, ena, addra} !== {2'b01, ADDR_W'(1)}) begin
      errors++;
      $display("FAIL after_restart err=%b ena=%b addra=%0d, expected 0 1 1", frame_err, ena, addra);
    end
    to_drive();
    cam_sof   = 1'b1;
    cam_valid = 1'b0;
    to_sample();
    checks++;
    if ({frame_err, ena} !== 2'b10) begin
      errors++;
      $display("FAIL sof_mid_no_valid err=%b ena=%b, expected 1 0", frame_err, ena);
    end
    to_drive();
    idle_inputs();
  endtask

  task automatic test_freeze();
    for (int unsigned a = 0; a < NUM_PIXELS; a++) begin
      to_drive();
      cam_sof    = (a == 0);
      cam_valid  = 1'b1;
      cam_data   = pix(4, a);
      freeze_req = (a >= 100);
      wq.push_back('{addr: ADDR_W'(a), data: pix(4, a)});
      to_sample();
      checks++;
      if ({frozen, frame_done, frame_err} !== {1'b0, (a == NUM_PIXELS - 1), 1'b0}) begin
        errors++;
        $display("FAIL freeze_frame a=%0d frozen/done/err=%b%b%b, expected 0%b0",
                 a, frozen, frame_done, frame_err, (a == NUM_PIXELS - 1));
      end
    end
    for (int unsigned i = 0; i < 3; i++) begin
      to_drive();
      cam_sof   = (i == 0);
      cam_valid = 1'b1;
      cam_data  = 16'hDEAD;
      to_sample();
      checks++;
      if ({frozen, ena, frame_err, frame_done} !== 4'b1000) begin
        errors++;
        $display("FAIL frozen_hold i=%0d frozen/ena/err/done=%b%b%b%b, expected 1000",
                 i, frozen, ena, frame_err, frame_done);
      end
    end
    to_drive();
    freeze_req = 1'b0;
    cam_sof    = 1'b0;
    to_sample();
    checks++;
    if ({frozen, ena} !== 2'b10) begin
      errors++;
      $display("FAIL unfreeze_cycle frozen/ena=%b%b, expected 10", frozen, ena);
    end
    to_drive();
    to_sample();
    checks++;
    if ({frozen, ena} !== 2'b00) begin
      errors++;
      $display("FAIL unfrozen_wait frozen/ena=%b%b, expected 00", frozen, ena);
    end
    to_drive();
    cam_sof  = 1'b1;
    cam_data = pix(5, 0);
    wq.push_back('{addr: '0, data: pix(5, 0)});
    to_sample();
    checks++;
    if ({ena, frozen, frame_err} !== 3'b100) begin
      errors++;
      $display("FAIL unfrozen_sof ena/frozen/err=%b%b%b, expected 100", ena, frozen, frame_err);
    end
  endtask

  task automatic test_reset_mid();
    for (int unsigned a = 1; a <= 7000; a++) begin
      to_drive();
      cam_sof   = 1'b0;
      cam_valid = 1'b1;
      cam_data  = pix(5, a);
      wq.push_back('{addr: ADDR_W'(a), data: pix(5, a)});
      if (a == 7000) begin
        det_req  = 1'b1;
        det_addr = ADDR_W'(300);
      end
      to_sample();
    end
    checks++;
    if ({det_gnt, enb, addrb} !== {2'b11, ADDR_W'(300)}) begin
      errors++;
      $display("FAIL inflight_grant tg=%b enb=%b addrb=%0d, expected 1 1 300", det_gnt, enb, addrb);
    end
    to_drive();
    rst = 1'b1;
    idle_inputs();
    to_sample();
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs got=%h, expected 0", all_out);
    end
    to_drive();
    rst       = 1'b0;
    cam_valid = 1'b1;
    cam_data  = 16'hFACE;
    to_sample();
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL after_reset_outputs got=%h, expected 0", all_out);
    end
    to_drive();
    cam_sof  = 1'b1;
    cam_data = pix(6, 0);
    wq.push_back('{addr: '0, data: pix(6, 0)});
    to_sample();
    checks++;
    if ({ena, addra, frame_err} !== {1'b1, ADDR_W'(0), 1'b0}) begin
      errors++;
      $display("FAIL restart_after_reset ena=%b addra=%0d err=%b, expected 1 0 0", ena, addra, frame_err);
    end
    to_drive();
    idle_inputs();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_frame();
    test_arbitration();
    test_out_of_range();
    test_sof_align();
    test_freeze();
    test_reset_mid();
    to_sample();
    #1;
    checks++;
    if (wq.size() != 0 || rq.size() != 0) begin
      errors++;
      $display("FAIL final_queues writes=%0d reads=%0d, expected 0 0", wq.size(), rq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
